// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply-unit controller: datapath width,
// MDU op encodings and controller state encoding.
package mdu_pkg;

    localparam int MDU_W = 32;

    // Op field as presented on the op port.
    typedef enum logic [1:0] {
        MDU_MULTU = 2'b00,
        MDU_MULT  = 2'b01,
        MDU_MTHI  = 2'b10,
        MDU_MTLO  = 2'b11
    } mdu_op_e;

    // Controller states: waiting for an op, or holding operands on the multiplier.
    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate, width-parameterized.
// Used as the magnitude stage on each 32-bit operand (neg = sign bit of a
// signed operand) and as the 64-bit sign correction on the product.
// The most negative value maps to itself, which read as unsigned is the
// correct magnitude.
module mdu_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    // Invert-and-increment when negation is requested, pass-through otherwise.
    always_comb begin
        res = neg ? (~val + W'(1)) : val;
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply-unit controller: sequences an external 32x32 unsigned
// combinational multiplier over a fixed MUL_LATENCY-cycle window, applies
// sign correction for MULT and owns the HI/LO registers (incl. MTHI/MTLO).
// Optional build macro: MDU_CANCEL_EN adds a `cancel` input that aborts an
// in-flight multiply without touching HI/LO.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [MDU_W-1:0]     rs_val,
    input  logic [MDU_W-1:0]     rt_val,
`ifdef MDU_CANCEL_EN
    input  logic                 cancel,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [MDU_W-1:0]     hi,
    output logic [MDU_W-1:0]     lo,
    output logic                 mul_en,
    output logic [MDU_W-1:0]     mul_a,
    output logic [MDU_W-1:0]     mul_b,
    input  logic [2*MDU_W-1:0]   mul_z
);

    // 4 bits covers the full 1..15 latency range (counter starts at L-1).
    localparam int CNT_W = 4;

    mdu_state_e            state, state_nxt;
    mdu_op_e               op_e;
    logic [CNT_W-1:0]      cnt;
    logic                  neg;
    logic                  is_mul;
    logic                  is_mult;
    logic                  abort;
    logic [1:0][MDU_W-1:0] opnd_in;
    logic [1:0][MDU_W-1:0] opnd_mag;
    logic [2*MDU_W-1:0]    prod;

    assign op_e    = mdu_op_e'(op);
    assign is_mul  = (op_e == MDU_MULTU) || (op_e == MDU_MULT);
    assign is_mult = (op_e == MDU_MULT);

`ifdef MDU_CANCEL_EN
    assign abort = cancel;
`else
    assign abort = 1'b0;
`endif

    // Index 0 is operand A (rs), index 1 is operand B (rt).
    assign opnd_in = {rt_val, rs_val};

    // Operand magnitude: only signed MULT operands with the sign bit set are negated.
    for (genvar g = 0; g < 2; g++) begin : g_opnd
        mdu_sign_fix #(.W(MDU_W)) u_opnd_fix (
            .val (opnd_in[g]),
            .neg (is_mult & opnd_in[g][MDU_W-1]),
            .res (opnd_mag[g])
        );
    end

    // Product sign correction from the sign captured at issue.
    mdu_sign_fix #(.W(2*MDU_W)) u_prod_fix (
        .val (mul_z),
        .neg (neg),
        .res (prod)
    );

    // Both strobes are pure state decodes so they never glitch with inputs.
    assign busy   = (state == CALC);
    assign mul_en = (state == CALC);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: multiplies enter CALC; CALC leaves on abort or when the count expires.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start && is_mul) state_nxt = CALC;
            CALC: if (abort || (cnt == '0)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, latency count, HI/LO update and done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_a <= '0;
            mul_b <= '0;
            neg   <= 1'b0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                // Requests are only looked at in IDLE; anything during CALC is dropped.
                if (start) begin
                    case (op_e)
                        MDU_MULTU, MDU_MULT: begin
                            mul_a <= opnd_mag[0];
                            mul_b <= opnd_mag[1];
                            neg   <= is_mult & (rs_val[MDU_W-1] ^ rt_val[MDU_W-1]);
                            cnt   <= CNT_W'(MUL_LATENCY - 1);
                        end
                        MDU_MTHI: hi <= rs_val;
                        MDU_MTLO: lo <= rs_val;
                        default: ;
                    endcase
                end
            end else begin
                // Abort wins over completion; HI/LO keep their old contents.
                if (!abort) begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        {hi, lo} <= prod;
                        done     <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed and randomized MDU ops checked
// against a behavioural HI/LO model built from plain 64-bit arithmetic.
module tb_mdu_ctrl;

    localparam int L = 2;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        mul_en;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_z;
`ifdef MDU_CANCEL_EN
    logic        cancel;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mdu_ctrl #(.MUL_LATENCY(L)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
`ifdef MDU_CANCEL_EN
        .cancel (cancel),
`endif
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo),
        .mul_en (mul_en),
        .mul_a  (mul_a),
        .mul_b  (mul_b),
        .mul_z  (mul_z)
    );

    // External combinational multiplier; outputs junk when not enabled so a
    // product sampled outside CALC shows up as a wrong HI/LO.
    assign mul_z = mul_en ? ({32'b0, mul_a} * {32'b0, mul_b}) : 64'h0BAD_0BAD_0BAD_0BAD;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0000_0001;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issue a multiply from IDLE and follow it to completion.
    // junk=1 drives other requests on every busy cycle; they must be ignored.
    task automatic do_mul(input logic is_signed, input logic [31:0] a, input logic [31:0] b,
                          input bit junk);
        logic signed [63:0] sa, sb;
        logic [63:0] ep;
        logic [31:0] ea, eb;
        if (is_signed) begin
            sa = $signed(a);
            sb = $signed(b);
            ep = sa * sb;
            ea = a[31] ? (32'd0 - a) : a;
            eb = b[31] ? (32'd0 - b) : b;
        end else begin
            ep = {32'b0, a} * {32'b0, b};
            ea = a;
            eb = b;
        end
        chk("idle_before_start", {63'b0, busy}, 64'd0);
        start  = 1'b1;
        op     = is_signed ? 2'b01 : 2'b00;
        rs_val = a;
        rt_val = b;
        @(negedge clk);
        start = 1'b0;
        chk("mul_a", {32'b0, mul_a}, {32'b0, ea});
        chk("mul_b", {32'b0, mul_b}, {32'b0, eb});
        for (int i = 0; i < L; i++) begin
            chk("busy_calc", {63'b0, busy}, 64'd1);
            chk("mul_en_calc", {63'b0, mul_en}, 64'd1);
            chk("done_calc", {63'b0, done}, 64'd0);
            chk("hilo_calc", {hi, lo}, {exp_hi, exp_lo});
            if (junk) begin
                start = 1'b1;
                if (i == 0) begin
                    op = 2'b11; rs_val = 32'h0000_DEAD; rt_val = 32'h0;
                end else if (i == 1) begin
                    op = 2'b01; rs_val = 32'd2; rt_val = 32'd2;
                end else begin
                    op = 2'($urandom_range(0, 3)); rs_val = $urandom; rt_val = $urandom;
                end
            end
            @(negedge clk);
        end
        start  = 1'b0;
        exp_hi = ep[63:32];
        exp_lo = ep[31:0];
        chk("done_pulse", {63'b0, done}, 64'd1);
        chk("busy_after", {63'b0, busy}, 64'd0);
        chk("hi_result", {32'b0, hi}, {32'b0, exp_hi});
        chk("lo_result", {32'b0, lo}, {32'b0, exp_lo});
        chk("mul_a_hold", {32'b0, mul_a}, {32'b0, ea});
    endtask

    // MTHI (is_hi=1) or MTLO from IDLE.
    task automatic do_mt(input bit is_hi, input logic [31:0] v);
        start  = 1'b1;
        op     = is_hi ? 2'b10 : 2'b11;
        rs_val = v;
        rt_val = $urandom;
        @(negedge clk);
        start = 1'b0;
        if (is_hi) exp_hi = v;
        else       exp_lo = v;
        chk("mt_busy", {63'b0, busy}, 64'd0);
        chk("mt_done", {63'b0, done}, 64'd0);
        chk("mt_hilo", {hi, lo}, {exp_hi, exp_lo});
    endtask

    initial begin
        reset  = 1'b0;
        start  = 1'b0;
        op     = 2'b00;
        rs_val = '0;
        rt_val = '0;
`ifdef MDU_CANCEL_EN
        cancel = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_mul_en", {63'b0, mul_en}, 64'd0);
        chk("rst_mul_ab", {mul_a, mul_b}, 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Directed cases.
        do_mul(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        do_mul(1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0);
        chk("mult_neg3x5", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        do_mul(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
        chk("mult_minxmin", {hi, lo}, 64'h4000_0000_0000_0000);
        @(negedge clk);
        chk("done_one_cycle", {63'b0, done}, 64'd0);
        do_mt(1'b1, 32'h1234_5678);
        do_mt(1'b0, 32'h9ABC_DEF0);
        chk("mt_pair", {hi, lo}, 64'h1234_5678_9ABC_DEF0);

        // Requests while busy are dropped.
        do_mul(1'b0, 32'd7, 32'd6, 1'b1);
        chk("ignore_busy", {hi, lo}, 64'd42);

        // Back-to-back: next start lands in the done cycle.
        do_mul(1'b1, $urandom, $urandom, 1'b0);
        do_mul(1'b0, $urandom, $urandom, 1'b0);

        // Randomized mix.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: do_mul(1'b0, pick_val(), pick_val(), bit'($urandom_range(0, 1)));
                1: do_mul(1'b1, pick_val(), pick_val(), bit'($urandom_range(0, 1)));
                2: do_mt(1'b1, $urandom);
                default: do_mt(1'b0, $urandom);
            endcase
            if ($urandom_range(0, 2) == 0) begin
                @(negedge clk);
                chk("idle_done_low", {63'b0, done}, 64'd0);
                chk("idle_hilo", {hi, lo}, {exp_hi, exp_lo});
            end
        end

        // Asynchronous reset in the middle of a MULT.
        start = 1'b1; op = 2'b01; rs_val = 32'hFFFF_FFFF; rt_val = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        chk("pre_reset_busy", {63'b0, busy}, 64'd1);
        reset = 1'b0;
        #1;
        exp_hi = '0;
        exp_lo = '0;
        chk("midrst_busy", {63'b0, busy}, 64'd0);
        chk("midrst_done", {63'b0, done}, 64'd0);
        chk("midrst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < L + 2; i++) begin
            @(negedge clk);
            chk("post_rst_done", {63'b0, done}, 64'd0);
            chk("post_rst_hilo", {hi, lo}, 64'd0);
        end

`ifdef MDU_CANCEL_EN
        // Cancel on the last CALC cycle beats completion.
        do_mt(1'b1, 32'h1111_1111);
        do_mt(1'b0, 32'h1111_1111);
        start = 1'b1; op = 2'b00; rs_val = 32'd3; rt_val = 32'd3;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < L - 1; i++) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_done", {63'b0, done}, 64'd0);
        chk("cancel_busy", {63'b0, busy}, 64'd0);
        chk("cancel_hilo", {hi, lo}, 64'h1111_1111_1111_1111);
        // Cancel while idle changes nothing; a following multiply completes.
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_idle", {hi, lo}, 64'h1111_1111_1111_1111);
        do_mul(1'b0, 32'd3, 32'd3, 1'b0);
        chk("after_cancel", {hi, lo}, 64'd9);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
